coin_dispense_sequencer: RTL and testbench



---
 rtl/coin_dispense_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_coin_dispense_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_dispense_sequencer.sv
// coin_dispense_sequencer: runs one push/retract servo stroke per coin,
// watchdogs the servo done flags, reports progress/done/fault upstream.
// Build option: DISPENSE_ABORT_EN adds the 'abort' level input.
// Ports:
//   clk, clr            clock, async active-high reset
//   dispense_req        level request, sampled in IDLE
//   dispense_count      coins to dispense, captured on accept
//   servoBackDone       low while a push stroke settles
//   servoFrontDone      low while a retract stroke settles
//   abort               (DISPENSE_ABORT_EN) stop after current coin
//   servoCtrl           bit 0: 1 push, 0 retract; bits 31:1 zero
//   dispense_ack        one-cycle pulse on accept
//   busy                accept until the cycle after done
//   dispense_done       one-cycle pulse at end of sequence
//   dispensed           coins completed in current/last sequence
//   fault               sticky, cleared on next accept
module coin_dispense_sequencer #(
   parameter int COUNT_W        = 4,
   parameter int ACK_WAIT       = 8,
   parameter int TIMEOUT_CYCLES = 40_000_000
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               dispense_req,
   input  logic [COUNT_W-1:0] dispense_count,
   input  logic               servoBackDone,
   input  logic               servoFrontDone,
`ifdef DISPENSE_ABORT_EN
   input  logic               abort,
`endif
   output logic [31:0]        servoCtrl,
   output logic               dispense_ack,
   output logic               busy,
   output logic               dispense_done,
   output logic [COUNT_W-1:0] dispensed,
   output logic               fault
);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_PUSH         = 3'd1;
   localparam logic [2:0] S_PUSH_WAIT    = 3'd2;
   localparam logic [2:0] S_RETRACT      = 3'd3;
   localparam logic [2:0] S_RETRACT_WAIT = 3'd4;
   localparam logic [2:0] S_FINISH       = 3'd5;
   localparam logic [2:0] S_FAULT        = 3'd6;

   // Timer matches limit-1 so the move happens after exactly 'limit' cycles.
   localparam logic [31:0] ACK_LIM = 32'(ACK_WAIT - 1);
   localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES - 1);

   logic [2:0]         state_q, state_d;
   logic [31:0]        timer_q, timer_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [COUNT_W-1:0] disp_q, disp_d;
   logic [COUNT_W-1:0] disp_inc;
   logic               ctrl_q, ctrl_d;
   logic               ack_q, ack_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               fault_q, fault_d;
   logic               stop_now;

`ifdef DISPENSE_ABORT_EN
   logic stop_q, stop_d;

   // Abort is remembered for the rest of the sequence; the coin in
   // flight always completes before the sequence stops.
   always_comb begin
      stop_d = stop_q;
      if (state_q == S_IDLE) begin
         stop_d = 1'b0;
      end else if (abort && (state_q inside {S_PUSH, S_PUSH_WAIT,
                                             S_RETRACT, S_RETRACT_WAIT})) begin
         stop_d = 1'b1;
      end
   end

   assign stop_now = stop_q | abort;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) stop_q <= 1'b0;
      else     stop_q <= stop_d;
   end
`else
   assign stop_now = 1'b0;
`endif

   assign disp_inc = disp_q + COUNT_W'(1);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      disp_d  = disp_q;
      ctrl_d  = ctrl_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;
      busy_d  = busy_q;
      fault_d = fault_q;
      unique case (state_q)
         S_IDLE: begin
            // busy_q still high here marks the cycle showing done;
            // no accept until it has dropped.
            busy_d = 1'b0;
            if (!busy_q && dispense_req && servoBackDone && servoFrontDone) begin
               ack_d   = 1'b1;
               busy_d  = 1'b1;
               fault_d = 1'b0;
               disp_d  = '0;
               count_d = dispense_count;
               if (dispense_count == '0) begin
                  state_d = S_FINISH;
               end else begin
                  ctrl_d  = 1'b1;
                  state_d = S_PUSH;
               end
            end
         end
         S_PUSH: begin
            if (!servoBackDone) begin
               state_d = S_PUSH_WAIT;
            end else if (timer_q == ACK_LIM) begin
               ctrl_d  = 1'b0;
               state_d = S_FAULT;
            end
         end
         S_PUSH_WAIT: begin
            if (servoBackDone) begin
               ctrl_d  = 1'b0;
               state_d = S_RETRACT;
            end else if (timer_q == TMO_LIM) begin
               ctrl_d  = 1'b0;
               state_d = S_FAULT;
            end
         end
         S_RETRACT: begin
            if (!servoFrontDone) begin
               state_d = S_RETRACT_WAIT;
            end else if (timer_q == ACK_LIM) begin
               state_d = S_FAULT;
            end
         end
         S_RETRACT_WAIT: begin
            if (servoFrontDone) begin
               disp_d = disp_inc;
               if ((disp_inc == count_q) || stop_now) begin
                  state_d = S_FINISH;
               end else begin
                  ctrl_d  = 1'b1;
                  state_d = S_PUSH;
               end
            end else if (timer_q == TMO_LIM) begin
               state_d = S_FAULT;
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_FAULT: begin
            ctrl_d  = 1'b0;
            fault_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            ctrl_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Timer restarts on every state entry and idles at zero.
   assign timer_d = ((state_d != state_q) || (state_q == S_IDLE)) ?
                    '0 : timer_q + 32'd1;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         count_q <= '0;
         disp_q  <= '0;
         ctrl_q  <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         count_q <= count_d;
         disp_q  <= disp_d;
         ctrl_q  <= ctrl_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   assign servoCtrl     = {31'd0, ctrl_q};
   assign dispense_ack  = ack_q;
   assign busy          = busy_q;
   assign dispense_done = done_q;
   assign dispensed     = disp_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// tb_coin_dispense_sequencer: servo-stage model plus scoreboard of
// expected end-of-sequence results for coin_dispense_sequencer.
module tb_coin_dispense_sequencer;

   localparam int CW     = 4;
   localparam int AW     = 8;
   localparam int TO     = 100;
   localparam int SETTLE = 50;
   localparam int COIN   = 2 * SETTLE + 2;

   logic          clk   = 1'b0;
   logic          clr   = 1'b1;
   logic          req   = 1'b0;
   logic [CW-1:0] cnt   = '0;
   logic          back  = 1'b1;
   logic          front = 1'b1;
   logic [31:0]   ctrl;
   logic          ack, busy, done, fault;
   logic [CW-1:0] disp;
`ifdef DISPENSE_ABORT_EN
   logic          abort = 1'b0;
`endif

   typedef struct {
      int disp;
      int fault;
      int lat;
      int push;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   time  t_ack = 0;
   int   a0 = 0, d0 = 0, p0 = 0;

   always #5 clk = ~clk;

   coin_dispense_sequencer #(
      .COUNT_W(CW), .ACK_WAIT(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .clr(clr),
      .dispense_req(req),
      .dispense_count(cnt),
      .servoBackDone(back),
      .servoFrontDone(front),
`ifdef DISPENSE_ABORT_EN
      .abort(abort),
`endif
      .servoCtrl(ctrl),
      .dispense_ack(ack),
      .busy(busy),
      .dispense_done(done),
      .dispensed(disp),
      .fault(fault)
   );

   // Servo stage model: a change on ctrl[0] drops the matching done
   // flag, which returns after the settle time.
   int   push_settle = SETTLE;
   bit   ign_ret     = 1'b0;
   logic prev_c      = 1'b0;
   int   settle      = 0;

   always @(negedge clk) begin
      if (ctrl[0] != prev_c) begin
         prev_c <= ctrl[0];
         if (ctrl[0]) begin
            back   <= 1'b0;
            settle <= push_settle;
         end else if (!ign_ret) begin
            front  <= 1'b0;
            settle <= SETTLE;
         end
      end else if (settle > 1) begin
         settle <= settle - 1;
      end else if (settle == 1) begin
         settle <= 0;
         back   <= 1'b1;
         front  <= 1'b1;
      end
   end

   // Event counters read by the main flow.
   int            n_push = 0, n_ack = 0, n_done = 0, n_bad = 0;
   logic          prev_m = 1'b0;
   logic [CW-1:0] prev_d = '0;

   always @(negedge clk) begin
      if (ctrl[0] && !prev_m) n_push <= n_push + 1;
      if (ack)  n_ack  <= n_ack + 1;
      if (done) n_done <= n_done + 1;
      if (disp != prev_d && disp != '0 && 32'(disp) != 32'(prev_d) + 1)
         n_bad <= n_bad + 1;
      prev_m <= ctrl[0];
      prev_d <= disp;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int d, input int f, input int lat,
                           input int p);
      exp_t e;
      e.disp  = d;
      e.fault = f;
      e.lat   = lat;
      e.push  = p;
      sb.push_back(e);
   endtask

   task automatic req_go(input int c, output bit ok);
      a0  = n_ack;
      d0  = n_done;
      p0  = n_push;
      ok  = 1'b0;
      cnt = CW'(c);
      req = 1'b1;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         if (ack) ok = 1'b1;
      end
      t_ack = $time;
      cnt   = '1;
      chk("ack_seen", 32'(ok), 1);
      if (ok) begin
         chk("ack_busy", 32'(busy), 1);
         chk("ack_ctrl", ctrl, 32'(c != 0));
         chk("ack_fault", 32'(fault), 0);
         chk("ack_disp", 32'(disp), 0);
      end
   endtask

   task automatic wait_done();
      exp_t e;
      bit   seen;
      seen = 1'b0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      req = 1'b0;
      chk("done_seen", 32'(seen), 1);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         if (seen) begin
            chk("done_disp", 32'(disp), e.disp);
            chk("done_fault", 32'(fault), e.fault);
            chk("done_ctrl", ctrl, 0);
            chk("done_busy", 32'(busy), 1);
            chk("done_lat", 32'(($time - t_ack) / 10), e.lat);
            @(negedge clk);
            chk("done_pulse", 32'(done), 0);
            chk("busy_low", 32'(busy), 0);
            chk("fault_hold", 32'(fault), e.fault);
            chk("disp_hold", 32'(disp), e.disp);
            chk("n_ack", n_ack - a0, 1);
            chk("n_done", n_done - d0, 1);
            chk("n_push", n_push - p0, e.push);
            chk("disp_step", n_bad, 0);
         end
      end
   endtask

   initial begin
      bit ok;
      bit bs;
      int nack, hold, dbase, k;

      repeat (3) @(negedge clk);
      chk("rst_ctrl", ctrl, 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_disp", 32'(disp), 0);
      chk("rst_fault", 32'(fault), 0);
      clr = 1'b0;
      repeat (2) @(negedge clk);

      // Normal 3 coins; req held through the sequence must not re-accept.
      push_exp(3, 0, 3 * COIN + 1, 3);
      req_go(3, ok);
      wait_done();

      // Count 0: straight to done.
      push_exp(0, 0, 1, 0);
      req_go(0, ok);
      wait_done();

      // Back flag stuck low: push-wait timeout.
      push_settle = 200;
      push_exp(0, 1, TO + 2, 1);
      req_go(1, ok);
      wait_done();
      push_settle = SETTLE;

      // Retract ignored: ack-wait timeout in the first retract.
      ign_ret = 1'b1;
      push_exp(0, 1, SETTLE + AW + 2, 1);
      req_go(2, ok);
      wait_done();
      ign_ret = 1'b0;

      // Recovery clears fault and completes.
      push_exp(2, 0, 2 * COIN + 1, 2);
      req_go(2, ok);
      wait_done();

      // clr during push-wait of coin 2 of 4.
      req_go(4, ok);
      req = 1'b0;
      k = 0;
      while (n_push < p0 + 2 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("clr_reach", 32'(n_push >= p0 + 2), 1);
      repeat (10) @(negedge clk);
      chk("clr_pre_disp", 32'(disp), 1);
      dbase = n_done;
      clr = 1'b1;
      #1;
      chk("clr_ctrl", ctrl, 0);
      chk("clr_busy", 32'(busy), 0);
      chk("clr_disp", 32'(disp), 0);
      chk("clr_done", 32'(done), 0);
      @(negedge clk);
      clr = 1'b0;
      #1;

      // Request held while back flag is low gets no ack.
      cnt  = CW'(1);
      req  = 1'b1;
      bs   = back;
      nack = 0;
      hold = 0;
      for (int i = 0; i < 500 && !bs; i++) begin
         @(negedge clk);
         #1;
         if (ack) nack++;
         hold++;
         bs = back;
      end
      chk("hold_seen", 32'(hold > 0), 1);
      chk("hold_noack", nack, 0);
      chk("clr_nodone", n_done - dbase, 0);
      push_exp(1, 0, COIN + 1, 1);
      req_go(1, ok);
      wait_done();

`ifdef DISPENSE_ABORT_EN
      // Abort in push-wait of coin 2: coin 2 completes, then done.
      push_exp(2, 0, 2 * COIN + 1, 2);
      req_go(5, ok);
      k = 0;
      while (n_push < p0 + 2 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done();
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
